io_out_display: RTL and testbench



---
 rtl/io_out_display.sv | 145 ++++++++++++++
 tb/tb_io_out_display.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_out_display.sv
// Output display stage: three CPU output ports shown as two decimal digits each on
// six active-low seven-segment displays, refreshed round-robin by one shared converter.
module io_out_display (
    input  logic        clock,
    input  logic        resetn,
    input  logic [31:0] out_port0,
    input  logic [31:0] out_port1,
    input  logic [31:0] out_port2,
    output logic [6:0]  hex0,
    output logic [6:0]  hex1,
    output logic [6:0]  hex2,
    output logic [6:0]  hex3,
    output logic [6:0]  hex4,
    output logic [6:0]  hex5,
    output logic        frame_done
);

    localparam int          W        = 7;
    localparam logic [6:0]  SEG_ZERO = 7'b1000000;
    localparam logic [6:0]  SEG_DASH = 7'b0111111;

    typedef enum logic [1:0] {
        LOAD,
        SHIFT,
        STORE
    } state_e;

    state_e         state_q;
    logic [1:0]     ch_q;
    logic           ovf_q;
    logic [W-1:0]   bin_q;
    logic [7:0]     bcd_q;
    logic [2:0]     cnt_q;
    logic [6:0]     hex0_q, hex1_q, hex2_q, hex3_q, hex4_q, hex5_q;
    logic           frame_done_q;

    logic [31:0]    sel_port;
    logic [7:0]     bcd_adj;
    logic [6:0]     tens_seg;
    logic [6:0]     ones_seg;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = 7'b1111111;
        endcase
    endfunction

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        sel_port = out_port0;
        case (ch_q)
            2'd1:    sel_port = out_port1;
            2'd2:    sel_port = out_port2;
            default: sel_port = out_port0;
        endcase

        // Shift-add-3: correct each BCD nibble before it is doubled.
        bcd_adj = bcd_q;
        if (bcd_q[3:0] >= 4'd5) bcd_adj[3:0] = bcd_q[3:0] + 4'd3;
        if (bcd_q[7:4] >= 4'd5) bcd_adj[7:4] = bcd_q[7:4] + 4'd3;

        tens_seg = ovf_q ? SEG_DASH : seg7(bcd_q[7:4]);
        ones_seg = ovf_q ? SEG_DASH : seg7(bcd_q[3:0]);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // sees the pre-edge values of the others regardless of statement order.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q      <= LOAD;
            ch_q         <= 2'd0;
            ovf_q        <= 1'b0;
            bin_q        <= '0;
            bcd_q        <= '0;
            cnt_q        <= '0;
            hex0_q       <= SEG_ZERO;
            hex1_q       <= SEG_ZERO;
            hex2_q       <= SEG_ZERO;
            hex3_q       <= SEG_ZERO;
            hex4_q       <= SEG_ZERO;
            hex5_q       <= SEG_ZERO;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            case (state_q)
                LOAD: begin
                    // Full-width compare so large values show dashes, not their low bits.
                    ovf_q   <= (sel_port > 32'd99);
                    bin_q   <= sel_port[W-1:0];
                    bcd_q   <= '0;
                    cnt_q   <= '0;
                    state_q <= SHIFT;
                end
                SHIFT: begin
                    {bcd_q, bin_q} <= {bcd_adj[6:0], bin_q, 1'b0};
                    cnt_q          <= cnt_q + 3'd1;
                    if (cnt_q == 3'(W - 1)) state_q <= STORE;
                end
                STORE: begin
                    case (ch_q)
                        2'd0: begin
                            hex1_q <= tens_seg;
                            hex0_q <= ones_seg;
                        end
                        2'd1: begin
                            hex3_q <= tens_seg;
                            hex2_q <= ones_seg;
                        end
                        default: begin
                            hex5_q <= tens_seg;
                            hex4_q <= ones_seg;
                        end
                    endcase
                    if (ch_q == 2'd2) begin
                        ch_q         <= 2'd0;
                        frame_done_q <= 1'b1;
                    end else begin
                        ch_q <= ch_q + 2'd1;
                    end
                    state_q <= LOAD;
                end
                default: state_q <= LOAD;
            endcase
        end
    end

    assign hex0       = hex0_q;
    assign hex1       = hex1_q;
    assign hex2       = hex2_q;
    assign hex3       = hex3_q;
    assign hex4       = hex4_q;
    assign hex5       = hex5_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_io_out_display.sv
// Directed bench for io_out_display: reset, static values, overflow, port changes,
// an incrementing-port scoreboard and reset mid-conversion.
module tb_io_out_display;

    localparam logic [6:0] DASH = 7'b0111111;
    localparam logic [6:0] ZERO = 7'b1000000;
    localparam logic [6:0] SEG [10] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };

    logic        clock;
    logic        resetn;
    logic [31:0] out_port0, out_port1, out_port2;
    logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5;
    logic        frame_done;
    logic [6:0]  hex_a [6];

    int checks = 0;
    int errors = 0;

    io_out_display dut (
        .clock      (clock),
        .resetn     (resetn),
        .out_port0  (out_port0),
        .out_port1  (out_port1),
        .out_port2  (out_port2),
        .hex0       (hex0),
        .hex1       (hex1),
        .hex2       (hex2),
        .hex3       (hex3),
        .hex4       (hex4),
        .hex5       (hex5),
        .frame_done (frame_done)
    );

    assign hex_a[0] = hex0;
    assign hex_a[1] = hex1;
    assign hex_a[2] = hex2;
    assign hex_a[3] = hex3;
    assign hex_a[4] = hex4;
    assign hex_a[5] = hex5;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [6:0] exp_tens(input int v);
        return (v > 99) ? DASH : SEG[v / 10];
    endfunction

    function automatic logic [6:0] exp_ones(input int v);
        return (v > 99) ? DASH : SEG[v % 10];
    endfunction

    // Advance n rising edges, then settle on the following falling edge.
    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        @(negedge clock);
    endtask

    // Returns on the falling edge where frame_done is high; next edge is ch0 LOAD.
    task automatic wait_frame(input string name);
        int k = 0;
        tick(1);
        while (frame_done !== 1'b1 && k < 60) begin
            tick(1);
            k++;
        end
        checks++;
        if (frame_done !== 1'b1) begin
            errors++;
            $display("FAIL %s: frame_done timeout got %b expected 1", name, frame_done);
        end
    endtask

    task automatic test_reset();
        resetn    = 1'b0;
        out_port0 = 32'd42;
        out_port1 = 32'd7;
        out_port2 = 32'd99;
        tick(5);
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (hex_a[i] !== ZERO) begin
                errors++;
                $display("FAIL reset_hex%0d: got %b expected %b", i, hex_a[i], ZERO);
            end
        end
        checks++;
        if (frame_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_frame_done: got %b expected 0", frame_done);
        end
        resetn = 1'b1;
    endtask

    // Released on a falling edge, so the next rising edge is cycle 0.
    task automatic test_static();
        tick(8);
        checks++;
        if (hex0 !== ZERO) begin
            errors++;
            $display("FAIL static_hex0_early: got %b expected %b", hex0, ZERO);
        end
        tick(1);
        checks++;
        if ({hex1, hex0} !== {7'b0011001, 7'b0100100}) begin
            errors++;
            $display("FAIL static_42: got %b %b expected 0011001 0100100", hex1, hex0);
        end
        tick(9);
        checks++;
        if ({hex3, hex2} !== {7'b1000000, 7'b1111000}) begin
            errors++;
            $display("FAIL static_07: got %b %b expected 1000000 1111000", hex3, hex2);
        end
        tick(8);
        checks++;
        if (frame_done !== 1'b0) begin
            errors++;
            $display("FAIL frame_done_early: got %b expected 0", frame_done);
        end
        tick(1);
        checks++;
        if (frame_done !== 1'b1) begin
            errors++;
            $display("FAIL frame_done_26: got %b expected 1", frame_done);
        end
        checks++;
        if ({hex5, hex4} !== {7'b0010000, 7'b0010000}) begin
            errors++;
            $display("FAIL static_99: got %b %b expected 0010000 0010000", hex5, hex4);
        end
        tick(1);
        checks++;
        if (frame_done !== 1'b0) begin
            errors++;
            $display("FAIL frame_done_27: got %b expected 0", frame_done);
        end
    endtask

    // Entered just after ch0 LOAD of frame 2 captured 42.
    task automatic test_overflow();
        out_port0 = 32'd100;
        out_port1 = 32'hFFFF_FFFF;
        out_port2 = 32'd127;
        wait_frame("overflow_frame1");
        checks++;
        if ({hex1, hex0, hex3, hex2} !== {7'b0011001, 7'b0100100, DASH, DASH}) begin
            errors++;
            $display("FAIL overflow_partial: got %b %b %b %b expected 42 held, ch1 dashes",
                     hex1, hex0, hex3, hex2);
        end
        wait_frame("overflow_frame2");
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (hex_a[i] !== DASH) begin
                errors++;
                $display("FAIL overflow_hex%0d: got %b expected %b", i, hex_a[i], DASH);
            end
        end
    endtask

    task automatic test_mid_change();
        out_port0 = 32'd25;
        tick(1);
        tick(2);
        out_port0 = 32'd63;
        tick(6);
        checks++;
        if ({hex1, hex0} !== {7'b0100100, 7'b0010010}) begin
            errors++;
            $display("FAIL mid_change_25: got %b %b expected 0100100 0010010", hex1, hex0);
        end
        wait_frame("mid_change_frame");
        tick(9);
        checks++;
        if ({hex1, hex0} !== {7'b0000010, 7'b0110000}) begin
            errors++;
            $display("FAIL mid_change_63: got %b %b expected 0000010 0110000", hex1, hex0);
        end
        wait_frame("mid_change_end");
    endtask

    task automatic test_incrementing();
        int p0 = 0;
        int p1 = 1;
        int p2 = 85;
        int c0 = 0;
        int c1 = 0;
        int c2 = 0;
        for (int e = 0; e < 81; e++) begin
            if (e % 5 == 0 && e > 0) begin
                p0++;
                p1++;
                p2++;
            end
            out_port0 = 32'(p0);
            out_port1 = 32'(p1);
            out_port2 = 32'(p2);
            tick(1);
            case (e % 27)
                0:  c0 = p0;
                9:  c1 = p1;
                18: c2 = p2;
                8: begin
                    checks++;
                    if ({hex1, hex0} !== {exp_tens(c0), exp_ones(c0)}) begin
                        errors++;
                        $display("FAIL incr_ch0 e=%0d: got %b %b expected value %0d",
                                 e, hex1, hex0, c0);
                    end
                end
                17: begin
                    checks++;
                    if ({hex3, hex2} !== {exp_tens(c1), exp_ones(c1)}) begin
                        errors++;
                        $display("FAIL incr_ch1 e=%0d: got %b %b expected value %0d",
                                 e, hex3, hex2, c1);
                    end
                end
                26: begin
                    checks++;
                    if ({frame_done, hex5, hex4} !== {1'b1, exp_tens(c2), exp_ones(c2)}) begin
                        errors++;
                        $display("FAIL incr_ch2 e=%0d: got fd=%b %b %b expected fd=1 value %0d",
                                 e, frame_done, hex5, hex4, c2);
                    end
                end
                default: ;
            endcase
        end
    endtask

    task automatic test_reset_mid();
        out_port0 = 32'd42;
        out_port1 = 32'd7;
        out_port2 = 32'd99;
        tick(12);
        resetn = 1'b0;
        #1;
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (hex_a[i] !== ZERO) begin
                errors++;
                $display("FAIL reset_mid_hex%0d: got %b expected %b", i, hex_a[i], ZERO);
            end
        end
        tick(2);
        resetn = 1'b1;
        tick(9);
        checks++;
        if ({hex1, hex0, hex3} !== {7'b0011001, 7'b0100100, ZERO}) begin
            errors++;
            $display("FAIL reset_mid_ch0_first: got %b %b %b expected 0011001 0100100 1000000",
                     hex1, hex0, hex3);
        end
        tick(18);
        checks++;
        if (frame_done !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_fd26: got %b expected 1", frame_done);
        end
        tick(1);
        checks++;
        if (frame_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_fd27: got %b expected 0", frame_done);
        end
        tick(26);
        checks++;
        if (frame_done !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_fd53: got %b expected 1", frame_done);
        end
    endtask

    initial begin
        test_reset();
        test_static();
        test_overflow();
        test_mid_change();
        test_incrementing();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
